// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and width bounds for the gray_counter block.
package gray_pkg;

  localparam int unsigned GRAY_WIDTH_MIN = 2;
  localparam int unsigned GRAY_WIDTH_MAX = 16;

  // Widest supported word; narrower counters zero-extend into it.
  typedef logic [GRAY_WIDTH_MAX-1:0] gray_word_t;

  // Next-state operation selected each cycle (load > en > hold).
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } gray_op_e;

  // Binary to reflected Gray code. Zero-extension leaves the result intact.
  function automatic gray_word_t bin_to_gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic gray_word_t gray_to_bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_WIDTH_MAX-1] = g[GRAY_WIDTH_MAX-1];
    for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter used on the counter load path.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each output bit is the reduction XOR of the Gray bits from the MSB down to
  // that position; written per bit so no bit depends on another output bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-coded mirror, Gray load,
// and selectable wrap-around or saturating terminal behaviour.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_g,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
  output logic             sat
);

  if ((WIDTH < GRAY_WIDTH_MIN) || (WIDTH > GRAY_WIDTH_MAX)) begin : g_bad_width
    $error("gray_counter: WIDTH=%0d is outside the legal range %0d..%0d",
           WIDTH, GRAY_WIDTH_MIN, GRAY_WIDTH_MAX);
  end

  localparam logic [WIDTH-1:0] CNT_MIN = '0;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             sat_q,  sat_d;

  logic [WIDTH-1:0] load_bin;
  gray_op_e         op;
  logic             at_max;
  logic             at_min;
  gray_word_t       gray_wide;

  gray_to_bin #(
    .WIDTH (WIDTH)
  ) u_load_conv (
    .gray_i (load_g),
    .bin_o  (load_bin)
  );

  assign at_max = (bin_q == CNT_MAX);
  assign at_min = (bin_q == CNT_MIN);

  // Resolve the cycle's operation with load taking priority over counting.
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = up ? OP_INC : OP_DEC;
    end
  end

  // Next count, wrap pulse and saturation level for the selected operation.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    unique case (op)
      OP_LOAD: begin
        bin_d = load_bin;
        sat_d = 1'b0;
      end
      OP_INC: begin
        if (at_max) begin
          if (WRAP) begin
            bin_d  = CNT_MIN;
            wrap_d = 1'b1;
            sat_d  = 1'b0;
          end else begin
            sat_d  = 1'b1;
          end
        end else begin
          bin_d = bin_q + CNT_ONE;
          sat_d = 1'b0;
        end
      end
      OP_DEC: begin
        if (at_min) begin
          if (WRAP) begin
            bin_d  = CNT_MAX;
            wrap_d = 1'b1;
            sat_d  = 1'b0;
          end else begin
            sat_d  = 1'b1;
          end
        end else begin
          bin_d = bin_q - CNT_ONE;
          sat_d = 1'b0;
        end
      end
      default: begin
        bin_d = bin_q;
      end
    endcase
  end

  // Gray mirror is computed from the next binary value so gray_out comes
  // straight from a flop and always matches bin_out in the same cycle.
  always_comb begin
    gray_wide = bin_to_gray(gray_word_t'(bin_d));
    gray_d    = gray_wide[WIDTH-1:0];
  end

  // State registers; reset clears everything, including any pending wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_gray_counter.sv
`timescale 1ns/1ps
module tb_gray_counter;

  // Instance 0: WIDTH=4 wrap, instance 1: WIDTH=4 saturate, instance 2: WIDTH=8 wrap.
  logic clk = 1'b0;
  logic rst_n;
  logic en_v[3];
  logic up_v[3];
  logic ld_v[3];
  logic [7:0] lg_v[3];

  logic [3:0] bin_a, gray_a, bin_b, gray_b;
  logic [7:0] bin_c, gray_c;
  logic wrap_v[3];
  logic sat_v[3];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .up(up_v[0]), .load(ld_v[0]),
    .load_g(lg_v[0][3:0]), .bin_out(bin_a), .gray_out(gray_a),
    .wrap(wrap_v[0]), .sat(sat_v[0]));

  gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .up(up_v[1]), .load(ld_v[1]),
    .load_g(lg_v[1][3:0]), .bin_out(bin_b), .gray_out(gray_b),
    .wrap(wrap_v[1]), .sat(sat_v[1]));

  gray_counter #(.WIDTH(8), .WRAP(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_v[2]), .up(up_v[2]), .load(ld_v[2]),
    .load_g(lg_v[2]), .bin_out(bin_c), .gray_out(gray_c),
    .wrap(wrap_v[2]), .sat(sat_v[2]));

  function automatic int wid(int i);
    return (i == 2) ? 8 : 4;
  endfunction

  function automatic bit wmode(int i);
    return (i != 1);
  endfunction

  function automatic logic [7:0] dut_bin(int i);
    case (i)
      0:       return {4'b0, bin_a};
      1:       return {4'b0, bin_b};
      default: return bin_c;
    endcase
  endfunction

  function automatic logic [7:0] dut_gray(int i);
    case (i)
      0:       return {4'b0, gray_a};
      1:       return {4'b0, gray_b};
      default: return gray_c;
    endcase
  endfunction

  // Reference model: plain integer count, range check for wrap/saturation.
  typedef struct packed {
    logic [15:0] cnt;
    logic        w;
    logic        s;
    logic        st;
  } mstate_t;

  mstate_t m[3];

  // Gray decode by search: the unique n whose Gray code equals g.
  function automatic int g2b(int g, int w);
    for (int n = 0; n < (1 << w); n++) begin
      if ((n ^ (n >> 1)) == g) return n;
    end
    return 0;
  endfunction

  function automatic mstate_t step(int i, mstate_t s);
    mstate_t r;
    int mx;
    int nxt;
    mx   = (1 << wid(i)) - 1;
    r    = s;
    r.w  = 1'b0;
    r.st = !ld_v[i] && en_v[i];
    if (ld_v[i]) begin
      r.cnt = 16'(g2b(int'(lg_v[i]) & mx, wid(i)));
      r.s   = 1'b0;
    end else if (en_v[i]) begin
      nxt = up_v[i] ? int'(s.cnt) + 1 : int'(s.cnt) - 1;
      if (nxt < 0 || nxt > mx) begin
        if (wmode(i)) begin
          r.cnt = (nxt < 0) ? 16'(mx) : 16'd0;
          r.w   = 1'b1;
          r.s   = 1'b0;
        end else begin
          r.s   = 1'b1;
        end
      end else begin
        r.cnt = 16'(nxt);
        r.s   = 1'b0;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) m[i] <= step(i, m[i]);
    end
  end

  // Compare process: every falling edge, all three instances against the model,
  // plus single-bit Gray change on each counting step that moved the count.
  logic [7:0] prev_gray[3];
  logic [7:0] prev_bin[3];
  logic [15:0] eg;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      eg = m[i].cnt ^ (m[i].cnt >> 1);
      vecs++;
      if (dut_bin(i) !== m[i].cnt[7:0] || dut_gray(i) !== eg[7:0] ||
          wrap_v[i] !== m[i].w || sat_v[i] !== m[i].s) begin
        errs++;
        $display("FAIL model[%0d] t=%0t: got bin=%0h gray=%0h wrap=%0b sat=%0b, expected bin=%0h gray=%0h wrap=%0b sat=%0b",
                 i, $time, dut_bin(i), dut_gray(i), wrap_v[i], sat_v[i],
                 m[i].cnt[7:0], eg[7:0], m[i].w, m[i].s);
      end
      if (rst_n && m[i].st && dut_bin(i) !== prev_bin[i]) begin
        vecs++;
        if ($countones(dut_gray(i) ^ prev_gray[i]) != 1) begin
          errs++;
          $display("FAIL onebit[%0d] t=%0t: gray %0h -> %0h, required exactly one bit change",
                   i, $time, prev_gray[i], dut_gray(i));
        end
      end
      prev_gray[i] = dut_gray(i);
      prev_bin[i]  = dut_bin(i);
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s t=%0t: got %0h, expected %0h", nm, $time, got, exp);
    end
  endtask

  logic [3:0] seq[17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                          4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                          4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en_v[i] = 1'b0; up_v[i] = 1'b0; ld_v[i] = 1'b0; lg_v[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    chk("reset bin_a", 16'(bin_a), 16'h0);
    chk("reset gray_c", 16'(gray_c), 16'h0);
    chk("reset wrap_a", 16'(wrap_v[0]), 16'h0);
    chk("reset sat_b", 16'(sat_v[1]), 16'h0);
    rst_n = 1'b1;

    // 17-value up-count sequence with wrap on the last step.
    en_v[0] = 1'b1; up_v[0] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("seq gray[%0d]", k), 16'(gray_a), 16'(seq[k]));
      chk($sformatf("seq wrap[%0d]", k), 16'(wrap_v[0]), (k == 16) ? 16'h1 : 16'h0);
    end

    // Down one step from reset wraps to all-ones.
    en_v[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en_v[0] = 1'b1; up_v[0] = 1'b0;
    @(negedge clk);
    chk("down bin", 16'(bin_a), 16'hF);
    chk("down gray", 16'(gray_a), 16'h8);
    chk("down wrap", 16'(wrap_v[0]), 16'h1);
    en_v[0] = 1'b0;
    @(negedge clk);
    chk("down wrap drop", 16'(wrap_v[0]), 16'h0);

    // Load wins over enable, then counting continues from the loaded value.
    ld_v[0] = 1'b1; lg_v[0] = 8'h0D; en_v[0] = 1'b1; up_v[0] = 1'b1;
    @(negedge clk);
    chk("load bin", 16'(bin_a), 16'h9);
    chk("load gray", 16'(gray_a), 16'hD);
    ld_v[0] = 1'b0;
    @(negedge clk);
    chk("load+1 bin", 16'(bin_a), 16'hA);
    en_v[0] = 1'b0;

    // Saturation at both terminals.
    ld_v[1] = 1'b1; lg_v[1] = 8'h08;
    @(negedge clk);
    chk("sat load bin", 16'(bin_b), 16'hF);
    ld_v[1] = 1'b0; en_v[1] = 1'b1; up_v[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sat hi bin", 16'(bin_b), 16'hF);
      chk("sat hi sat", 16'(sat_v[1]), 16'h1);
      chk("sat hi wrap", 16'(wrap_v[1]), 16'h0);
    end
    up_v[1] = 1'b0;
    @(negedge clk);
    chk("sat leave bin", 16'(bin_b), 16'hE);
    chk("sat leave sat", 16'(sat_v[1]), 16'h0);
    ld_v[1] = 1'b1; lg_v[1] = 8'h00;
    @(negedge clk);
    ld_v[1] = 1'b0;
    @(negedge clk);
    chk("sat lo bin", 16'(bin_b), 16'h0);
    chk("sat lo sat", 16'(sat_v[1]), 16'h1);
    en_v[1] = 1'b0;
    @(negedge clk);
    chk("sat hold", 16'(sat_v[1]), 16'h1);
    en_v[1] = 1'b1; up_v[1] = 1'b1;
    @(negedge clk);
    chk("sat lo leave bin", 16'(bin_b), 16'h1);
    chk("sat lo leave sat", 16'(sat_v[1]), 16'h0);
    en_v[1] = 1'b0;

    // Asynchronous reset mid-cycle while counting at 0111.
    ld_v[0] = 1'b1; lg_v[0] = 8'h04;
    @(negedge clk);
    chk("pre-rst bin", 16'(bin_a), 16'h7);
    ld_v[0] = 1'b0; en_v[0] = 1'b1; up_v[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async bin_a", 16'(bin_a), 16'h0);
    chk("async gray_a", 16'(gray_a), 16'h0);
    chk("async bin_b", 16'(bin_b), 16'h0);
    chk("async bin_c", 16'(bin_c), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst bin", 16'(bin_a), 16'h1);
    chk("post-rst wrap", 16'(wrap_v[0]), 16'h0);

    // Random stream on all instances; direction is sticky so terminals get hit.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 3; i++) begin
        ld_v[i] = ($urandom_range(0, 15) == 0);
        lg_v[i] = 8'($urandom);
        en_v[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 31) == 0) up_v[i] = ~up_v[i];
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
